// File: rtl/bomb_input_sequencer.sv
// -----------------------------------------------------------------------------
// bomb_input_sequencer
//
// Game-logic stage feeding the VGA renderer. The six raw player buttons are
// synchronized, debounced and edge-detected; each accepted press is stored in
// an 8-slot history. A full history is compared against a secret sequence.
// A match defuses the bomb. A mismatch clears the history and adds a strike,
// and too many strikes detonate it. A countdown timer also detonates it when
// it expires. Everything runs on the pixel clock, so the outputs need no
// clock-domain crossing before they reach the display controller.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a raw level is accepted
//   TIMEOUT_CYCLES   cycles allowed before the bomb explodes (31-bit counter)
//   SECRET           expected code of slot i in SECRET[3i+2:3i]
//   MAX_STRIKES      failed full-sequence checks that cause an explosion
//
// Ports
//   vga_clk    in   sole clock (pixel clock)
//   rst        in   synchronous active-high reset
//   btn_raw    in   [5:0] asynchronous button pins, bit n = code n
//                   (LEFT=0, RIGHT=1, UP=2, DOWN=3, A=4, B=5)
//   buttons    out  [3:0] x [0:7] slot entries {valid, code}, empty = 4'h0
//   state      out  [1:0] 0 ARMED, 1 DEFUSED, 2 EXPLODED
//   strikes    out  [1:0] failed checks so far
//   time_left  out  [30:0] remaining timeout cycles
// -----------------------------------------------------------------------------
module bomb_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES  = 1500000000,
  parameter logic [23:0] SECRET          = 24'h9486D2,
  parameter int unsigned MAX_STRIKES     = 3
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [5:0]  btn_raw,
  output logic [3:0]  buttons [0:7],
  output logic [1:0]  state,
  output logic [1:0]  strikes,
  output logic [30:0] time_left
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [30:0] TIMEOUT_INIT = 31'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAST_SLOT    = 3'd7;

  // Encoding seen by the display controller.
  localparam logic [1:0] ST_ARMED    = 2'd0;
  localparam logic [1:0] ST_DEFUSED  = 2'd1;
  localparam logic [1:0] ST_EXPLODED = 2'd2;

  typedef enum logic [1:0] {
    S_ENTRY,
    S_CHECK,
    S_DEFUSED,
    S_EXPLODED
  } fsm_e;

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchronizer, per-bit debouncer, rising-edge detector
  // ---------------------------------------------------------------------------
  logic [5:0]      sync1_q;
  logic [5:0]      sync2_q;
  logic [5:0]      deb_q;
  logic [5:0]      deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [6];

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      // NOTE: sequential state is always written with <= so every register
      // samples the pre-edge value of its neighbours, just like the hardware.
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 6; i++) begin
        // Count consecutive cycles in which the synchronized level disagrees
        // with the accepted level; any agreement restarts the count.
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle pulse on each rising edge of a debounced level. Both operands
  // are registers, so there is no combinational path from btn_raw.
  logic [5:0] evt;
  assign evt = deb_q & ~deb_prev_q;

  // Simultaneous presses: the lowest-numbered code wins, the rest are dropped.
  logic       evt_any;
  logic [2:0] evt_code;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned (which would infer a latch).
    evt_any  = 1'b0;
    evt_code = '0;
    for (int i = 5; i >= 0; i--) begin
      if (evt[i]) begin
        evt_any  = 1'b1;
        evt_code = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  fsm_e        fsm_q;
  logic [1:0]  state_q;
  logic [1:0]  strikes_q;
  logic [30:0] time_left_q;
  logic [2:0]  wr_idx_q;
  logic [3:0]  slots_q [0:7];

  // Full history matches the secret (every slot valid, every code equal).
  logic seq_match;

  always_comb begin
    seq_match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (slots_q[i] != {1'b1, SECRET[3*i +: 3]}) begin
        seq_match = 1'b0;
      end
    end
  end

  // Countdown helpers; the decrement saturates so a zero timeout cannot wrap.
  logic [30:0] time_left_d;
  logic        time_expire;
  logic [1:0]  strikes_d;
  logic        strike_limit;

  assign time_left_d  = (time_left_q == '0) ? '0 : time_left_q - 31'd1;
  assign time_expire  = (time_left_q <= 31'd1);
  assign strikes_d    = strikes_q + 2'd1;
  assign strike_limit = (32'(strikes_q) + 32'd1) >= MAX_STRIKES;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      fsm_q       <= S_ENTRY;
      state_q     <= ST_ARMED;
      strikes_q   <= '0;
      time_left_q <= TIMEOUT_INIT;
      wr_idx_q    <= '0;
      // NOTE: the slot array is reset because an empty slot must read 4'h0 on
      // the display; it is only eight small registers, not a RAM.
      for (int i = 0; i < 8; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      case (fsm_q)
        S_ENTRY: begin
          time_left_q <= time_left_d;
          if (time_expire) begin
            // An expiring timer outranks a press landing in the same cycle.
            fsm_q   <= S_EXPLODED;
            state_q <= ST_EXPLODED;
          end else if (evt_any) begin
            slots_q[wr_idx_q] <= {1'b1, evt_code};
            wr_idx_q          <= wr_idx_q + 3'd1;
            if (wr_idx_q == LAST_SLOT) begin
              fsm_q <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Presses arriving here are dropped: nothing reads evt_any.
          time_left_q <= time_left_d;
          if (seq_match) begin
            // A passing check wins even if the timer expires this cycle.
            fsm_q   <= S_DEFUSED;
            state_q <= ST_DEFUSED;
          end else begin
            for (int i = 0; i < 8; i++) begin
              slots_q[i] <= '0;
            end
            wr_idx_q  <= '0;
            strikes_q <= strikes_d;
            if (strike_limit || time_expire) begin
              fsm_q   <= S_EXPLODED;
              state_q <= ST_EXPLODED;
            end else begin
              fsm_q <= S_ENTRY;
            end
          end
        end

        // Terminal until reset: slots, strikes and timer are frozen.
        S_DEFUSED:  fsm_q <= S_DEFUSED;
        S_EXPLODED: fsm_q <= S_EXPLODED;
        default: begin
          fsm_q   <= S_EXPLODED;
          state_q <= ST_EXPLODED;
        end
      endcase
    end
  end

  assign buttons   = slots_q;
  assign state     = state_q;
  assign strikes   = strikes_q;
  assign time_left = time_left_q;

endmodule
